contador_gray: RTL and testbench
================================

# contador_gray

Parametrised synchronous Gray-code counter. It keeps the count in binary internally and presents registered binary and Gray outputs. Supports up/down counting, wrap or saturate at the limits, a parallel load given as either binary or Gray, and a terminal-count flag. It is the sequential successor to the combinational binary-to-Gray decoder, used for position encoders, clock-domain-safe pointers and rotary sequencing.

## Interface

**Parameters**
- `WIDTH`, default 4: counter width in bits; legal range 2..32.
- `WRAP`, default 1: 1 = wrap around at the limits; 0 = saturate at the limits.

**Ports**
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `en`  in  1: count enable; one step per edge while high.
- `up`  in  1: direction; 1 = increment, 0 = decrement.
- `load`  in  1: parallel load strobe.
- `load_gray`  in  1: 1 = `load_val` is Gray-coded; 0 = `load_val` is binary.
- `load_val`  in  WIDTH: value to load.
- `bin_out`  out  WIDTH: registered count, binary.
- `gray_out`  out  WIDTH: registered count, Gray (`bin ^ (bin >> 1)`).
- `tc`  out  1: terminal count, combinational.
- `sat`  out  1: saturation-hold indicator, registered; only meaningful when `WRAP=0`.

## Operation

**State:** binary register `cnt[WIDTH-1:0]`. `bin_out` and `gray_out` are both registered and derived from the same next value, so they always change on the same edge.

**Priority per edge:** `!rst_n` > `load` > `en` > hold.
- **Reset:** `cnt`, `bin_out`, `gray_out` = 0; `sat` = 0.
- **Load:** `cnt` = `load_val` if `load_gray=0`; otherwise `cnt` = gray2bin(`load_val`). `load` overrides `en` and `up`. `sat` clears.
- **Enabled step, not at the limit:** `cnt` = `cnt` + 1 when `up=1`, `cnt` − 1 when `up=0`, modulo 2^WIDTH.
- **Limits:** the limit is all-ones when counting up and zero when counting down.
  - `WRAP=1`: the counter wraps (all-ones→0, 0→all-ones).
  - `WRAP=0`: `cnt` holds and `sat` is set on that edge. `sat` clears on the next edge that moves `cnt` (reverse-direction step or load).
- **`en=0`:** hold. `sat` keeps its value.

**`tc` rule:** `tc = en & !load & (cnt == (up ? all-ones : 0))`. It goes high the cycle before a wrap or saturation, for use as a carry to cascade counters.

**Step invariant:** on every enabled step that moves `cnt`, `gray_out` changes in exactly one bit. This includes the wrap step (all-ones Gray `100..0` ↔ `000..0`).

**Direction change:** `up` may change on any cycle and takes effect on the same edge; there is no dead cycle.

## Timing

- **Latency:** 1 edge from `load`, `en` or `rst_n` to `bin_out`, `gray_out` and `sat`.
- **`tc`:** combinational from registered `cnt`, `en`, `load` and `up`. It is valid in the same cycle and has no register stage.
- **Reset mid-count:** the outputs reach 0 on the first edge with `rst_n=0`. The count resumes from 0 on the first edge after `rst_n` returns high (if `en=1`).
- **Load and reset together:** reset wins.
- **No combinational path** from `load_val` to any output except through the register.

## Structure

**Package `gray_pkg`:**
- function `bin2gray(WIDTH)`.
- function `gray2bin(WIDTH)`: prefix XOR from the MSB down.
- constant helpers for all-ones and zero limits.

**Sub-module `gray_a_binario`:** combinational Gray-to-binary converter, parametrised by `WIDTH`, instantiated on the load path. It is separately testable and reused by future pointer-synchroniser blocks.

**Top level:** next-state logic, limit/`tc` logic and the output registers.

## Test plan

1. **Reset:** `rst_n=0` for 2 edges with `en=1` → `bin_out=0000`, `gray_out=0000`, `sat=0`. `tc=0` when `up=1`.
2. **Full up-count,** `WIDTH=4`, `WRAP=1`, 17 enabled steps:
   - `gray_out` = 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, 0000.
   - `tc=1` only while `bin_out=1111`.
   - Each step changes exactly one Gray bit.
3. **Down-wrap:** from 0, `up=0`, `en=1` → `tc=1` before the edge; after the edge `bin_out=1111` and `gray_out=1000`.
4. **Loads:**
   - `load=1`, `load_gray=1`, `load_val=1101`, with `en=1` at the same time → next `bin_out=1001`, `gray_out=1101` (load wins).
   - `load_gray=0`, `load_val=0110` → `bin_out=0110`, `gray_out=0101`.
5. **Saturate mode,** `WRAP=0`:
   - Load 1110, 3 up steps → `bin_out` 1111, then holds at 1111. `sat=1` from the second step onward.
   - One down step → `bin_out=1110`, `sat=0`.
6. **Reset mid-count:** count to 0111, assert `rst_n=0` for 1 edge with `en=1` → `bin_out=0000`. After release, the next edge gives `0001`.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the counter and the pointer blocks that reuse it.
// The functions work on 32-bit zero-extended values. Callers size-cast the
// result back to their own width. Zero-extension keeps both conversions exact
// for any width up to 32.
package gray_pkg;

  localparam int unsigned MAX_WIDTH = 32;

  // Binary to Gray: each Gray bit is the XOR of a binary bit and its upper neighbour.
  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: prefix XOR taken from the MSB down.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b = '0;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Upper counting limit (all-ones) for a counter of width w.
  function automatic logic [MAX_WIDTH-1:0] lim_hi(input int unsigned w);
    logic [MAX_WIDTH-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      if (i < w) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Lower counting limit (zero) for a counter of width w.
  function automatic logic [MAX_WIDTH-1:0] lim_lo(input int unsigned w);
    logic [MAX_WIDTH-1:0] m;
    m = '0;
    if (w > MAX_WIDTH) m = '0;
    return m;
  endfunction

endpackage

// File: rtl/gray_a_binario.sv
// Combinational Gray-to-binary converter, sized by WIDTH.
// It sits on the counter's load path and is meant for pointer synchronisers.
module gray_a_binario
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out
);

  // Zero-extend, convert, and take the low WIDTH bits back.
  always_comb begin
    bin_out = '0;
    bin_out = WIDTH'(gray2bin(MAX_WIDTH'(gray_in)));
  end

endmodule

// File: rtl/contador_gray.sv
// Synchronous up/down counter with registered binary and Gray outputs.
// The count is held in binary. The Gray output is registered from the same
// next value, so both outputs change on the same edge.
// Edge priority: reset > load > enabled step > hold.
module contador_gray
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned WRAP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic             load_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             tc,
  output logic             sat
);

  localparam logic [WIDTH-1:0] LIMIT_UP = WIDTH'(lim_hi(WIDTH));
  localparam logic [WIDTH-1:0] LIMIT_DN = WIDTH'(lim_lo(WIDTH));
  localparam logic             DO_WRAP  = (WRAP != 0);

  logic [WIDTH-1:0] cnt_q,  cnt_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             sat_q,  sat_d;

  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] load_conv;
  logic             at_limit;

  // Gray-coded loads go through the shared converter.
  gray_a_binario #(
    .WIDTH (WIDTH)
  ) u_load_conv (
    .gray_in (load_val),
    .bin_out (load_conv)
  );

  // Select the load value in binary form.
  always_comb begin
    load_bin = load_val;
    if (load_gray) load_bin = load_conv;
  end

  // Check whether the count sits at the limit for the current direction.
  always_comb begin
    at_limit = 1'b0;
    if (up) at_limit = (cnt_q == LIMIT_UP);
    else    at_limit = (cnt_q == LIMIT_DN);
  end

  // Terminal count: high while the next enabled edge would wrap or saturate.
  always_comb begin
    tc = en & ~load & at_limit;
  end

  // Next count and saturation flag.
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (load) begin
      cnt_d = load_bin;
      sat_d = 1'b0;
    end else if (en) begin
      if (at_limit && !DO_WRAP) begin
        // Saturating mode holds at the limit and flags it.
        cnt_d = cnt_q;
        sat_d = 1'b1;
      end else begin
        // Modular arithmetic also covers the wrap case.
        if (up) cnt_d = cnt_q + WIDTH'(1);
        else    cnt_d = cnt_q - WIDTH'(1);
        sat_d = 1'b0;
      end
    end
  end

  // Gray output is derived from the same next value as the count.
  always_comb begin
    gray_d = WIDTH'(bin2gray(MAX_WIDTH'(cnt_d)));
  end

  // Output and state registers, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      gray_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      gray_q <= gray_d;
      sat_q  <= sat_d;
    end
  end

  assign bin_out  = cnt_q;
  assign gray_out = gray_q;
  assign sat      = sat_q;

endmodule

// File: tb/tb_contador_gray.sv
// Directed bench for contador_gray.
// One wrapping instance and one saturating instance share the same stimulus.
module tb_contador_gray;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       up;
  logic       load;
  logic       load_gray;
  logic [3:0] load_val;

  logic [3:0] bin_w, gray_w, bin_s, gray_s;
  logic       tc_w, sat_w, tc_s, sat_s;

  int n_total;
  int n_bad;

  logic [3:0] exp_q[$];

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  contador_gray #(.WIDTH(4), .WRAP(1)) u_dut_wrap (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .up        (up),
    .load      (load),
    .load_gray (load_gray),
    .load_val  (load_val),
    .bin_out   (bin_w),
    .gray_out  (gray_w),
    .tc        (tc_w),
    .sat       (sat_w)
  );

  contador_gray #(.WIDTH(4), .WRAP(0)) u_dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .up        (up),
    .load      (load),
    .load_gray (load_gray),
    .load_val  (load_val),
    .bin_out   (bin_s),
    .gray_out  (gray_s),
    .tc        (tc_s),
    .sat       (sat_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // One rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] gray_seq [17];
    logic [3:0] prev_g;
    logic [3:0] exp_g;

    n_total = 0;
    n_bad   = 0;
    gray_seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                 4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
    foreach (gray_seq[i]) exp_q.push_back(gray_seq[i]);

    // Reset for two edges with en high.
    rst_n = 1'b0; en = 1'b1; up = 1'b1;
    load = 1'b0; load_gray = 1'b0; load_val = 4'd0;
    tick();
    tick();
    check("rst_bin", 32'(bin_w), 32'h0);
    check("rst_gray", 32'(gray_w), 32'h0);
    check("rst_sat", 32'(sat_s), 32'h0);
    check("rst_tc", 32'(tc_w), 32'h0);

    // Full up-count with wrap.
    rst_n = 1'b1;
    prev_g = 4'd0;
    for (int i = 0; i < 17; i++) begin
      exp_g = exp_q.pop_front();
      check("up_gray", 32'(gray_w), 32'(exp_g));
      check("up_bin", 32'(bin_w), 32'(i % 16));
      check("up_tc", 32'(tc_w), 32'(i == 15));
      if (i > 0) check("up_onebit", 32'($countones(gray_w ^ prev_g)), 32'd1);
      prev_g = gray_w;
      if (i < 16) tick();
    end
    // The saturating instance stopped at the top.
    check("satup_bin", 32'(bin_s), 32'hf);
    check("satup_flag", 32'(sat_s), 32'h1);
    check("satup_tc", 32'(tc_s), 32'h1);

    // Down-wrap from zero.
    up = 1'b0;
    #1;
    check("dn_tc", 32'(tc_w), 32'h1);
    tick();
    check("dn_bin", 32'(bin_w), 32'hf);
    check("dn_gray", 32'(gray_w), 32'h8);
    check("satdn_bin", 32'(bin_s), 32'he);
    check("satdn_flag", 32'(sat_s), 32'h0);

    // A Gray load wins over en and masks tc.
    up = 1'b1; load = 1'b1; load_gray = 1'b1; load_val = 4'b1101;
    #1;
    check("ld_tc_masked", 32'(tc_w), 32'h0);
    tick();
    check("ldg_bin", 32'(bin_w), 32'h9);
    check("ldg_gray", 32'(gray_w), 32'hd);
    check("ldg_bin_s", 32'(bin_s), 32'h9);

    // Binary load.
    load_gray = 1'b0; load_val = 4'b0110;
    tick();
    check("ldb_bin", 32'(bin_w), 32'h6);
    check("ldb_gray", 32'(gray_w), 32'h5);

    // Saturation: load 1110, then three up steps.
    load_val = 4'b1110;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    check("s1_bin", 32'(bin_s), 32'hf);
    check("s1_sat", 32'(sat_s), 32'h0);
    check("s1_wbin", 32'(bin_w), 32'hf);
    tick();
    check("s2_bin", 32'(bin_s), 32'hf);
    check("s2_sat", 32'(sat_s), 32'h1);
    check("s2_wbin", 32'(bin_w), 32'h0);
    check("s2_wsat", 32'(sat_w), 32'h0);
    tick();
    check("s3_bin", 32'(bin_s), 32'hf);
    check("s3_sat", 32'(sat_s), 32'h1);
    check("s3_gray", 32'(gray_s), 32'h8);
    // With en low, the count and sat hold.
    en = 1'b0;
    #1;
    check("hold_tc", 32'(tc_s), 32'h0);
    tick();
    check("hold_bin", 32'(bin_s), 32'hf);
    check("hold_sat", 32'(sat_s), 32'h1);
    check("hold_wbin", 32'(bin_w), 32'h1);
    // A reverse step leaves the limit and clears sat.
    en = 1'b1; up = 1'b0;
    tick();
    check("rev_bin", 32'(bin_s), 32'he);
    check("rev_sat", 32'(sat_s), 32'h0);
    check("rev_wbin", 32'(bin_w), 32'h0);

    // Reset mid-count, with load asserted at the same time.
    load = 1'b1; load_gray = 1'b0; load_val = 4'b0110;
    tick();
    load = 1'b0; up = 1'b1;
    tick();
    check("mid_bin", 32'(bin_w), 32'h7);
    rst_n = 1'b0; load = 1'b1; load_val = 4'b1010;
    tick();
    check("mid_rst_bin", 32'(bin_w), 32'h0);
    check("mid_rst_gray", 32'(gray_w), 32'h0);
    rst_n = 1'b1; load = 1'b0;
    tick();
    check("mid_resume", 32'(bin_w), 32'h1);
    check("mid_resume_g", 32'(gray_w), 32'h1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
